// File: rtl/rtc_bus_if.sv
// PicoBlaze I/O and RTC pad signals of the RTC bus controller, bundled for port use.
// slave: the controller's view; master: the PicoBlaze/pad side.
interface rtc_bus_if;
   logic [7:0] port_id;
   logic [7:0] out_port;
   logic       write_strobe;
   logic       read_strobe;
   logic [7:0] in_port;
   logic       interrupt;
   logic       interrupt_ack;
   logic       rtc_cs_n;
   logic       rtc_wr_n;
   logic       rtc_rd_n;
   logic       rtc_as;
   logic [7:0] rtc_ad_out;
   logic       rtc_ad_oe;
   logic [7:0] rtc_ad_in;

   modport slave (
      input  port_id, out_port, write_strobe, read_strobe, interrupt_ack, rtc_ad_in,
      output in_port, interrupt, rtc_cs_n, rtc_wr_n, rtc_rd_n, rtc_as, rtc_ad_out, rtc_ad_oe
   );

   modport master (
      output port_id, out_port, write_strobe, read_strobe, interrupt_ack, rtc_ad_in,
      input  in_port, interrupt, rtc_cs_n, rtc_wr_n, rtc_rd_n, rtc_as, rtc_ad_out, rtc_ad_oe
   );
endinterface

// File: rtl/rtc_bus_ctrl.sv
// PicoBlaze I/O-mapped controller generating multiplexed address/data cycles to the RTC chip.
// Optional completion interrupt enabled by defining RTC_BUS_IRQ_EN.
module rtc_bus_ctrl #(
   parameter logic [7:0] PORT_BASE = 8'h00,
   parameter int         PHASE_CYC = 10
) (
   input  logic     clk,
   input  logic     rst,
   rtc_bus_if.slave bus
);
   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_A_SET = 3'd1,
      S_A_STB = 3'd2,
      S_A_HLD = 3'd3,
      S_D_SET = 3'd4,
      S_D_STB = 3'd5,
      S_D_HLD = 3'd6
   } state_t;

   localparam logic [7:0] PORT_ADDR = PORT_BASE;
   localparam logic [7:0] PORT_DATA = PORT_BASE + 8'd1;
   localparam logic [7:0] PORT_CMD  = PORT_BASE + 8'd2;
   localparam logic [7:0] CNT_LOAD  = 8'(PHASE_CYC - 1);

   state_t     state_q, state_d, state_nxt;
   logic [7:0] cnt_q, cnt_d;
   logic       is_read_q, is_read_d;
   logic [7:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
   logic       done_q, done_d, coll_q, coll_d;
   logic [7:0] in_port_q, in_port_d, ad_out_q, ad_out_d;
   logic       cs_n_q, cs_n_d, wr_n_q, wr_n_d, rd_n_q, rd_n_d;
   logic       as_q, as_d, oe_q, oe_d;
   logic       busy, wr_addr, wr_data, wr_cmd, rd_status, start_req;
   logic       done_evt, coll_evt, irq_bit;
   logic [7:0] status;
`ifdef RTC_BUS_IRQ_EN
   logic       irq_en_q, irq_en_d, int_q, int_d;
`endif

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      is_read_d = is_read_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      rdata_d   = rdata_q;
      done_d    = done_q;
      coll_d    = coll_q;
      done_evt  = 1'b0;
      coll_evt  = 1'b0;
      busy      = (state_q != S_IDLE);
      wr_addr   = bus.write_strobe && (bus.port_id == PORT_ADDR);
      wr_data   = bus.write_strobe && (bus.port_id == PORT_DATA);
      wr_cmd    = bus.write_strobe && (bus.port_id == PORT_CMD);
      rd_status = bus.read_strobe && (bus.port_id == PORT_ADDR);
      start_req = wr_data || (wr_cmd && bus.out_port[0]);

      case (state_q)
         S_A_SET: state_nxt = S_A_STB;
         S_A_STB: state_nxt = S_A_HLD;
         S_A_HLD: state_nxt = S_D_SET;
         S_D_SET: state_nxt = S_D_STB;
         S_D_STB: state_nxt = S_D_HLD;
         default: state_nxt = S_IDLE;
      endcase

      // Address writes and starts are refused while a cycle is in flight.
      if (busy) begin
         coll_evt = start_req || wr_addr;
         if (cnt_q == 8'd0) begin
            state_d = state_nxt;
            cnt_d   = CNT_LOAD;
            if ((state_q == S_D_STB) && is_read_q) begin
               rdata_d = bus.rtc_ad_in;
            end else begin
               rdata_d = rdata_q;
            end
            done_evt = (state_q == S_D_HLD);
         end else begin
            cnt_d = cnt_q - 8'd1;
         end
      end else begin
         if (wr_addr) begin
            addr_d = bus.out_port;
         end else begin
            addr_d = addr_q;
         end
         if (start_req) begin
            state_d   = S_A_SET;
            cnt_d     = CNT_LOAD;
            is_read_d = !wr_data;
            wdata_d   = wr_data ? bus.out_port : wdata_q;
         end else begin
            state_d = S_IDLE;
         end
      end

      // Set beats clear so an event on the clearing read is not lost.
      if (rd_status) begin
         done_d = 1'b0;
         coll_d = 1'b0;
      end else begin
         done_d = done_q;
         coll_d = coll_q;
      end
      if (done_evt) done_d = 1'b1;
      else          done_d = done_d;
      if (coll_evt) coll_d = 1'b1;
      else           coll_d = coll_d;

`ifdef RTC_BUS_IRQ_EN
      irq_en_d = wr_cmd ? bus.out_port[1] : irq_en_q;
      irq_bit  = irq_en_q;
      if (done_evt && irq_en_q) begin
         int_d = 1'b1;
      end else if (bus.interrupt_ack) begin
         int_d = 1'b0;
      end else begin
         int_d = int_q;
      end
`else
      irq_bit = 1'b0;
`endif

      status = {4'b0000, irq_bit, coll_q, done_q, busy};
      case (bus.port_id)
         PORT_ADDR: in_port_d = status;
         PORT_DATA: in_port_d = rdata_q;
         default:   in_port_d = 8'h00;
      endcase

      // Pad outputs decode the next state so they change on the entering edge.
      cs_n_d   = (state_d == S_IDLE);
      wr_n_d   = 1'b1;
      rd_n_d   = 1'b1;
      as_d     = 1'b0;
      oe_d     = 1'b0;
      ad_out_d = 8'h00;
      case (state_d)
         S_A_SET, S_A_STB, S_A_HLD: begin
            as_d     = 1'b1;
            oe_d     = 1'b1;
            ad_out_d = addr_d;
            wr_n_d   = (state_d != S_A_STB);
         end
         S_D_SET, S_D_STB, S_D_HLD: begin
            if (is_read_d) begin
               rd_n_d = (state_d != S_D_STB);
            end else begin
               oe_d     = 1'b1;
               ad_out_d = wdata_d;
               wr_n_d   = (state_d != S_D_STB);
            end
         end
         default: cs_n_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         cnt_q     <= 8'd0;
         is_read_q <= 1'b0;
         addr_q    <= 8'h00;
         wdata_q   <= 8'h00;
         rdata_q   <= 8'h00;
         done_q    <= 1'b0;
         coll_q    <= 1'b0;
         in_port_q <= 8'h00;
         cs_n_q    <= 1'b1;
         wr_n_q    <= 1'b1;
         rd_n_q    <= 1'b1;
         as_q      <= 1'b0;
         oe_q      <= 1'b0;
         ad_out_q  <= 8'h00;
`ifdef RTC_BUS_IRQ_EN
         irq_en_q  <= 1'b0;
         int_q     <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         is_read_q <= is_read_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         rdata_q   <= rdata_d;
         done_q    <= done_d;
         coll_q    <= coll_d;
         in_port_q <= in_port_d;
         cs_n_q    <= cs_n_d;
         wr_n_q    <= wr_n_d;
         rd_n_q    <= rd_n_d;
         as_q      <= as_d;
         oe_q      <= oe_d;
         ad_out_q  <= ad_out_d;
`ifdef RTC_BUS_IRQ_EN
         irq_en_q  <= irq_en_d;
         int_q     <= int_d;
`endif
      end
   end

   assign bus.in_port    = in_port_q;
   assign bus.rtc_cs_n   = cs_n_q;
   assign bus.rtc_wr_n   = wr_n_q;
   assign bus.rtc_rd_n   = rd_n_q;
   assign bus.rtc_as     = as_q;
   assign bus.rtc_ad_oe  = oe_q;
   assign bus.rtc_ad_out = ad_out_q;
`ifdef RTC_BUS_IRQ_EN
   assign bus.interrupt  = int_q;
`else
   assign bus.interrupt  = 1'b0;
`endif
endmodule

// File: tb/tb_rtc_bus_ctrl.sv
// Randomized self-checking bench for rtc_bus_ctrl against a phase-table reference model.
module tb_rtc_bus_ctrl;
   localparam int         P      = 2;
   localparam logic [7:0] BASE   = 8'h00;
   localparam logic [7:0] P_DATA = BASE + 8'd1;
   localparam logic [7:0] P_CMD  = BASE + 8'd2;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   rtc_bus_if bus();
   rtc_bus_ctrl #(.PORT_BASE(BASE), .PHASE_CYC(P)) dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   logic [7:0] m_addr, m_wdata, m_rdata;
   logic       m_done, m_coll, m_irq_en, m_int;

   function automatic logic [7:0] exp_status();
      logic ie;
`ifdef RTC_BUS_IRQ_EN
      ie = m_irq_en;
`else
      ie = 1'b0;
`endif
      return {4'b0000, ie, m_coll, m_done, 1'b0};
   endfunction

   function automatic logic exp_int();
`ifdef RTC_BUS_IRQ_EN
      return m_int;
`else
      return 1'b0;
`endif
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      m_addr = 8'h00; m_wdata = 8'h00; m_rdata = 8'h00;
      m_done = 1'b0; m_coll = 1'b0; m_irq_en = 1'b0; m_int = 1'b0;
   endtask

   task automatic check_idle(input string tag);
      checks++;
      if ({bus.rtc_cs_n, bus.rtc_wr_n, bus.rtc_rd_n, bus.rtc_as, bus.rtc_ad_oe} !== 5'b11100) begin
         errors++;
         $display("FAIL %s idle pads: got cs/wr/rd/as/oe=%b want 11100", tag,
                  {bus.rtc_cs_n, bus.rtc_wr_n, bus.rtc_rd_n, bus.rtc_as, bus.rtc_ad_oe});
      end
      checks++;
      if (bus.interrupt !== exp_int()) begin
         errors++;
         $display("FAIL %s interrupt: got %b want %b", tag, bus.interrupt, exp_int());
      end
   endtask

   task automatic write_port(input logic [7:0] p, input logic [7:0] d);
      bus.port_id = p; bus.out_port = d; bus.write_strobe = 1'b1;
      step();
      bus.write_strobe = 1'b0;
      if (p == BASE)  m_addr = d;
      if (p == P_CMD) m_irq_en = d[1];
   endtask

   task automatic read_port(input string tag, input logic [7:0] p, input logic [7:0] exp);
      bus.port_id = p; bus.read_strobe = 1'b1;
      step();
      bus.read_strobe = 1'b0;
      checks++;
      if (bus.in_port !== exp) begin
         errors++;
         $display("FAIL %s in_port[%h]: got %h want %h", tag, p, bus.in_port, exp);
      end
      if (p == BASE) begin
         m_done = 1'b0;
         m_coll = 1'b0;
      end
   endtask

   task automatic ack_irq();
      bus.interrupt_ack = 1'b1;
      step();
      bus.interrupt_ack = 1'b0;
      m_int = 1'b0;
   endtask

   // One full bus cycle; inj_k >= 0 writes inj_port during that clock of the cycle.
   task automatic run_cycle(input string tag, input logic rd, input logic [7:0] wd,
                            input logic [7:0] din, input int inj_k,
                            input logic [7:0] inj_port, input logic [7:0] inj_data);
      int         ph;
      logic       e_as, e_oe, e_wr, e_rd, ie_prev;
      logic [7:0] e_ad;
      ie_prev = m_irq_en;
      bus.port_id  = rd ? P_CMD : P_DATA;
      bus.out_port = rd ? {6'b000000, m_irq_en, 1'b1} : wd;
      bus.write_strobe = 1'b1;
      bus.rtc_ad_in = 8'($urandom);
      if (!rd) m_wdata = wd;
      step();
      bus.write_strobe = 1'b0;
      for (int k = 0; k < 6 * P; k++) begin
         ph   = k / P;
         e_as = (ph < 3);
         e_oe = (ph < 3) || !rd;
         e_wr = !((ph == 1) || (ph == 4 && !rd));
         e_rd = !(ph == 4 && rd);
         e_ad = (ph < 3) ? m_addr : m_wdata;
         checks++;
         if ({bus.rtc_cs_n, bus.rtc_wr_n, bus.rtc_rd_n, bus.rtc_as, bus.rtc_ad_oe} !==
             {1'b0, e_wr, e_rd, e_as, e_oe}) begin
            errors++;
            $display("FAIL %s pads k=%0d: got cs/wr/rd/as/oe=%b want %b", tag, k,
                     {bus.rtc_cs_n, bus.rtc_wr_n, bus.rtc_rd_n, bus.rtc_as, bus.rtc_ad_oe},
                     {1'b0, e_wr, e_rd, e_as, e_oe});
         end
         if (e_oe) begin
            checks++;
            if (bus.rtc_ad_out !== e_ad) begin
               errors++;
               $display("FAIL %s ad_out k=%0d: got %h want %h", tag, k, bus.rtc_ad_out, e_ad);
            end
         end
         checks++;
         if (bus.interrupt !== exp_int()) begin
            errors++;
            $display("FAIL %s interrupt k=%0d: got %b want %b", tag, k, bus.interrupt, exp_int());
         end
         bus.rtc_ad_in = (ph == 4) ? din : 8'($urandom);
         ie_prev = m_irq_en;
         if (k == inj_k) begin
            bus.port_id = inj_port; bus.out_port = inj_data; bus.write_strobe = 1'b1;
            if (inj_port == BASE || inj_port == P_DATA || (inj_port == P_CMD && inj_data[0]))
               m_coll = 1'b1;
            if (inj_port == P_CMD) m_irq_en = inj_data[1];
         end else begin
            bus.write_strobe = 1'b0;
         end
         step();
      end
      bus.write_strobe = 1'b0;
      if (rd) m_rdata = din;
      m_done = 1'b1;
`ifdef RTC_BUS_IRQ_EN
      if (ie_prev) m_int = 1'b1;
`endif
      check_idle(tag);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.port_id = P_DATA; bus.out_port = 8'h5A; bus.write_strobe = 1'b1;
      bus.read_strobe = 1'b0; bus.interrupt_ack = 1'b0; bus.rtc_ad_in = 8'h00;
      model_reset();
      repeat (3) step();
      check_idle("reset_held");
      checks++;
      if (bus.in_port !== 8'h00) begin
         errors++;
         $display("FAIL reset_in_port: got %h want 00", bus.in_port);
      end
      bus.write_strobe = 1'b0;
      rst = 1'b0;
      step();
      read_port("reset_status", BASE, 8'h00);
   endtask

   task automatic test_write();
      write_port(BASE, 8'h21);
      run_cycle("write", 1'b0, 8'h59, 8'h00, -1, 8'h00, 8'h00);
      read_port("write_status1", BASE, 8'h02);
      read_port("write_status2", BASE, 8'h00);
   endtask

   task automatic test_read();
      write_port(BASE, 8'h22);
      run_cycle("read", 1'b1, 8'h00, 8'h47, -1, 8'h00, 8'h00);
      read_port("read_data", P_DATA, 8'h47);
      read_port("read_status", BASE, exp_status());
   endtask

   task automatic test_collision();
      write_port(BASE, 8'h10);
      run_cycle("coll_data", 1'b0, 8'hA5, 8'h00, 1, P_DATA, 8'h3C);
      read_port("coll_status", BASE, 8'h06);
      run_cycle("coll_addr_last", 1'b0, 8'h66, 8'h00, 6 * P - 1, BASE, 8'hEE);
      read_port("coll_last_status", BASE, 8'h06);
   endtask

   task automatic test_back_to_back();
      write_port(BASE, 8'h31);
      run_cycle("b2b_1", 1'b0, 8'h11, 8'h00, -1, 8'h00, 8'h00);
      run_cycle("b2b_2", 1'b1, 8'h00, 8'h9C, -1, 8'h00, 8'h00);
      read_port("b2b_status", BASE, 8'h02);
      read_port("b2b_data", P_DATA, 8'h9C);
   endtask

   task automatic test_irq();
      write_port(P_CMD, 8'h02);
      run_cycle("irq", 1'b0, 8'h77, 8'h00, -1, 8'h00, 8'h00);
      repeat (3) step();
      check_idle("irq_hold");
      ack_irq();
      check_idle("irq_ack");
      read_port("irq_status", BASE, exp_status());
      write_port(P_CMD, 8'h00);
   endtask

   task automatic test_unmapped();
      read_port("unmapped_7f", 8'h7F, 8'h00);
      read_port("unmapped_cmd", P_CMD, 8'h00);
   endtask

   task automatic test_random();
      logic [7:0] ip;
      int         ik;
      for (int it = 0; it < 10; it++) begin
         write_port(BASE, 8'($urandom));
         case ($urandom_range(0, 3))
            0:       ip = BASE;
            1:       ip = P_DATA;
            2:       ip = P_CMD;
            default: ip = 8'h7F;
         endcase
         ik = ($urandom_range(0, 2) == 0) ? -1 : int'($urandom_range(0, 6 * P - 1));
         run_cycle("random", 1'($urandom), 8'($urandom), 8'($urandom), ik, ip, 8'($urandom));
         read_port("random_status", BASE, exp_status());
         read_port("random_data", P_DATA, m_rdata);
         ack_irq();
         check_idle("random_ack");
      end
      write_port(P_CMD, 8'h00);
   endtask

   task automatic test_reset_abort();
      write_port(BASE, 8'h44);
      bus.port_id = P_DATA; bus.out_port = 8'h88; bus.write_strobe = 1'b1;
      step();
      bus.write_strobe = 1'b0;
      repeat (P) step();
      checks++;
      if (bus.rtc_wr_n !== 1'b0) begin
         errors++;
         $display("FAIL abort_in_a_stb wr_n: got %b want 0", bus.rtc_wr_n);
      end
      #2 rst = 1'b1;
      #1;
      model_reset();
      check_idle("abort_async");
      step();
      rst = 1'b0;
      step();
      read_port("abort_status", BASE, 8'h00);
      check_idle("abort_after");
   endtask

   initial begin
      test_reset();
      test_write();
      test_read();
      test_collision();
      test_back_to_back();
      test_irq();
      test_unmapped();
      test_random();
      test_reset_abort();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
